// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - byte stream to 16-bit word block loader for memory port 1 (optional LOADER_CHECKSUM_EN)
module matrix_loader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, FINISH} state_t;

  // End-of-block limit compared one bit wider than the address so it cannot wrap
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr, remaining;
  logic [7:0]        hi_byte, lo_byte;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad, rx_take, accept;
  logic [DATA_W-1:0] word;

  assign end_addr  = {1'b0, base_addr} + {1'b0, word_count};
  assign range_bad = end_addr > DEPTH_LIM;
  assign accept    = (state == IDLE) && start && !range_bad;
  assign rx_take   = rx_valid && rx_ready;
  assign word      = DATA_W'({hi_byte, lo_byte});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; bytes are consumed only on a completed handshake
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (word_count == '0) ? FINISH : GET_HI;
      GET_HI:  if (rx_take) next_state = GET_LO;
      GET_LO:  if (rx_take) next_state = WRITE;
      WRITE:   next_state = (remaining == ADDR_W'(1)) ? FINISH : GET_HI;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered datapath and outputs; rx_ready/busy track the state they describe,
  // the write strobe and status pulses appear the cycle after their state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
      range_err <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      hi_byte   <= '0;
      lo_byte   <= '0;
    end else begin
      rx_ready  <= (next_state == GET_HI) || (next_state == GET_LO);
      busy      <= (next_state != IDLE);
      mem_we    <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && range_bad) range_err <= 1'b1;
          if (accept) begin
            ptr       <= base_addr;
            remaining <= word_count;
          end
        end
        GET_HI: if (rx_take) hi_byte <= rx_data;
        GET_LO: if (rx_take) lo_byte <= rx_data;
        WRITE: begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_data  <= word;
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        FINISH:  done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running modulo-2^16 sum of this load's words, restarted by each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sum_q <= '0;
    else if (accept)         sum_q <= '0;
    else if (state == WRITE) sum_q <= sum_q + word;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - randomized self-checking bench for matrix_loader against a memory-image model
module tb_matrix_loader;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MEM_DEPTH = 1000;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid;
  logic [ADDR_W-1:0] base_addr, word_count;
  logic [7:0]        rx_data;
  logic              rx_ready, mem_we, busy, done, range_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data, checksum;

  matrix_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .done(done), .range_err(range_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] tb_mem  [MEM_DEPTH];
  logic [15:0] exp_mem [MEM_DEPTH];
  logic [7:0]  byte_q [$];
  logic [15:0] load_words [$];
  int          cyc, gap, n_we, n_done, n_rerr, done_cyc, rerr_cyc, bad_addr;
  bit          saw_ready, hs_pend;
  logic [15:0] ck_at_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: observe what the last rising edge produced, then drive the byte source
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      if (int'(mem_addr) < MEM_DEPTH) tb_mem[mem_addr] = mem_data;
      else bad_addr++;
      n_we++;
    end
    if (done) begin n_done++; done_cyc = cyc; ck_at_done = checksum; end
    if (range_err) begin n_rerr++; rerr_cyc = cyc; end
    if (rx_ready) saw_ready = 1'b1;
    if (hs_pend && byte_q.size() > 0) void'(byte_q.pop_front());
    rx_valid = (byte_q.size() > 0) && (cyc % gap == 0);
    rx_data  = rx_valid ? byte_q[0] : 8'($urandom);
    hs_pend  = rx_valid && rx_ready;
  endtask

  task automatic compare_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (tb_mem[i] !== exp_mem[i]) bad++;
    check({name, " mem_image"}, bad, 0);
    check({name, " bad_addr"}, bad_addr, 0);
  endtask

  task automatic clear_counts();
    n_we = 0; n_done = 0; n_rerr = 0; done_cyc = -1; rerr_cyc = -1; saw_ready = 1'b0;
  endtask

  // Issue one load of load_words and check it against the block-level model
  task automatic run_load(input int base, input int count, input bit extra, input string name);
    int s;
    bit reject;
    logic [15:0] sum, exp_ck;
    reject = (base + count > MEM_DEPTH);
    if (!reject) foreach (load_words[i]) begin
      byte_q.push_back(load_words[i][15:8]);
      byte_q.push_back(load_words[i][7:0]);
    end
    clear_counts();
    base_addr = 16'(base); word_count = 16'(count); start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0; base_addr = 16'($urandom); word_count = 16'($urandom);
    for (int i = 0; i < 12 * count + 20 && n_done == 0 && n_rerr == 0; i++) begin
      if (extra && busy && $urandom_range(0, 3) == 0) begin
        base_addr = 16'($urandom_range(0, 50)); word_count = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
      end else tick();
    end
    repeat (3) tick();
    if (reject) begin
      check({name, " range_err"}, n_rerr, 1);
      check({name, " rerr_lat"}, rerr_cyc - s, 1);
      check({name, " writes"}, n_we, 0);
      check({name, " done"}, n_done, 0);
      byte_q.delete();
    end else begin
      check({name, " done"}, n_done, 1);
      check({name, " writes"}, n_we, count);
      if (gap == 1) check({name, " done_lat"}, done_cyc - s, 3 * count + 2);
      sum = 16'h0;
      foreach (load_words[i]) begin
        exp_mem[base + i] = load_words[i];
        sum = sum + load_words[i];
      end
`ifdef LOADER_CHECKSUM_EN
      exp_ck = sum;
`else
      exp_ck = 16'h0;
`endif
      check({name, " checksum"}, ck_at_done, exp_ck);
      check({name, " idle"}, busy, 0);
      check({name, " bytes_left"}, byte_q.size(), 0);
    end
    compare_mem(name);
    load_words.delete();
  endtask

  initial begin
    int base, count;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    base_addr = '0; word_count = '0; gap = 1; cyc = 0; hs_pend = 1'b0; bad_addr = 0;
    for (int i = 0; i < MEM_DEPTH; i++) begin tb_mem[i] = 16'h0; exp_mem[i] = 16'h0; end
    repeat (2) @(negedge clk);
    check("rst rx_ready", rx_ready, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_data", mem_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst range_err", range_err, 0);
    check("rst checksum", checksum, 0);
    rst = 1'b0;
    tick();

    load_words = '{16'h1234, 16'hABCD};
    run_load(10, 2, 1'b0, "basic");
    check("basic word10", tb_mem[10], 16'h1234);
    check("basic word11", tb_mem[11], 16'hABCD);
`ifdef LOADER_CHECKSUM_EN
    check("basic ck", ck_at_done, 16'hBE01);
`endif

    run_load(5, 0, 1'b0, "zero");
    check("zero no_ready", saw_ready, 0);

    load_words = '{16'h1, 16'h2, 16'h3};
    run_load(998, 3, 1'b0, "reject");
    load_words = '{16'h0A0B, 16'h0C0D, 16'h0E0F};
    run_load(997, 3, 1'b0, "edge");
    check("edge word999", tb_mem[999], 16'h0E0F);

    gap = 4;
    load_words = '{16'h1357, 16'h2468, 16'h9BDF, 16'h0F1E};
    run_load(300, 4, 1'b1, "gaps");
    gap = 1;

    load_words = '{16'h1111, 16'h2222};
    foreach (load_words[i]) begin
      byte_q.push_back(load_words[i][15:8]);
      byte_q.push_back(load_words[i][7:0]);
    end
    clear_counts();
    base_addr = 16'd200; word_count = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && byte_q.size() > 1; i++) tick();
    check("mid trigger", byte_q.size(), 1);
    rst = 1'b1;
    #1;
    check("mid rx_ready", rx_ready, 0);
    check("mid busy", busy, 0);
    check("mid mem_addr", mem_addr, 0);
    check("mid mem_data", mem_data, 0);
    check("mid checksum", checksum, 0);
    byte_q.delete(); hs_pend = 1'b0; rx_valid = 1'b0;
    exp_mem[200] = 16'h1111;
    load_words.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    check("mid writes", n_we, 1);
    compare_mem("mid");
    load_words = '{16'h3333, 16'h4444};
    run_load(200, 2, 1'b0, "after_rst");

    load_words = '{16'hFFFF, 16'h0002};
    run_load(50, 2, 1'b0, "wrap");
`ifdef LOADER_CHECKSUM_EN
    check("wrap ck", ck_at_done, 16'h0001);
`else
    check("wrap ck", ck_at_done, 16'h0000);
`endif

    for (int k = 0; k < 10; k++) begin
      base  = ($urandom_range(0, 2) == 0) ? $urandom_range(990, 999) : $urandom_range(0, 980);
      count = $urandom_range(0, 6);
      gap   = $urandom_range(1, 4);
      for (int i = 0; i < count; i++) load_words.push_back(16'($urandom));
      run_load(base, count, 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Sequential loader sitting directly upstream of the shared four-port data memory. It accepts a byte stream (typically from the UART receiver), assembles big-endian 16-bit words, and writes them to consecutive memory addresses through memory port 1, so host-supplied matrix operands are in place before the cores start. A single `start` pulse loads one block of `word_count` words beginning at `base_addr`.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory word width (fixed at two bytes)
- `MEM_DEPTH`, 1000, number of valid memory words (addresses 0..MEM_DEPTH-1)

- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `start` input 1 — one-cycle request to begin a load; sampled only in IDLE
- `base_addr` input ADDR_W — first write address, captured on accepted start
- `word_count` input ADDR_W — number of words to load, captured on accepted start
- `rx_data` input 8 — incoming byte
- `rx_valid` input 1 — `rx_data` valid
- `rx_ready` output 1 — loader accepts byte this cycle
- `mem_addr` output ADDR_W — to memory port 1 address
- `mem_data` output DATA_W — to memory port 1 write data
- `mem_we` output 1 — to memory port 1 write enable
- `busy` output 1 — load in progress
- `done` output 1 — one-cycle pulse, load complete
- `range_err` output 1 — one-cycle pulse, request rejected
- `checksum` output DATA_W — see Configuration

## Operation
- States: IDLE, GET_HI, GET_LO, WRITE, FINISH.
- IDLE: `start`=1 captures `base_addr`, `word_count`; remaining-count := `word_count`; write pointer := `base_addr`.
  - `base_addr + word_count > MEM_DEPTH` (computed at ADDR_W+1 bits, no wrap): pulse `range_err`, stay IDLE, no writes.
  - `word_count`=0: go to FINISH.
  - Otherwise go to GET_HI.
- GET_HI: `rx_ready`=1; on `rx_valid`, latch byte as word[15:8], go to GET_LO.
- GET_LO: `rx_ready`=1; on `rx_valid`, latch byte as word[7:0], go to WRITE.
- WRITE: `mem_we`=1 for exactly one cycle with `mem_addr`=pointer, `mem_data`=assembled word; pointer += 1, remaining -= 1; if remaining becomes 0 go to FINISH, else GET_HI.
- FINISH: `done`=1 for one cycle; return to IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored; no queueing.
- `rx_ready`=0 in IDLE, WRITE, FINISH; bytes presented then are not consumed.
- `mem_we` never asserted outside WRITE; `mem_addr`/`mem_data` hold last values otherwise.

## Timing
- Reset values: state IDLE, `rx_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_data` 0, `busy` 0, `done` 0, `range_err` 0, `checksum` 0.
- Reset mid-load: immediate return to IDLE; partial words discarded; already written words remain in memory.
- Byte handshake completes on rising edge with `rx_valid`&`rx_ready`.
- Minimum 3 cycles per word (HI, LO, WRITE) with `rx_valid` held high; N words take 3N+2 cycles from start to `done` (1 IDLE→GET_HI, 3N, 1 FINISH).
- `range_err` asserted the cycle after the rejected `start`.
- All outputs registered; no combinational path from `rx_valid` to `rx_ready`.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `checksum` = modulo-2^16 sum of every word written in the current load; cleared on accepted `start`; updated in WRITE; final value valid when `done` pulses and held until next accepted `start`.
- Not defined: adder and register removed; `checksum` tied to 0.

## Test plan
- Reset, start with base 10, count 2, bytes 12 34 AB CD → writes 0x1234 @10, 0xABCD @11, `done` at cycle 8 after start, checksum 0xBE01 (with macro).
- Count 0, base 5 → `done` pulse two cycles after start, no `mem_we`, `rx_ready` never high.
- Base 998, count 3 → `range_err` pulse, no writes; base 997, count 3 → accepted, last write @999.
- `rx_valid` gaps (valid every 4th cycle) with 4 words → all words correct, one `mem_we` per word, `start` pulses during load ignored.
- Assert `rst` after first byte of second word → outputs return to reset values immediately; only first word present in memory; new start loads normally.
- Checksum wrap: words 0xFFFF, 0x0002 → checksum 0x0001; without macro checksum stays 0.
